// File: rtl/image_process_ctrl.sv
// rtl/image_process_ctrl.sv - frame-aligned admission gate, config shadowing and geometry check for the pixel pipeline
module image_process_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int CNT_W      = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    single,
  input  logic [DATA_WIDTH-1:0]   cfg_threshold,
  input  logic [1:0]              cfg_out_sel,
  input  logic                    in_valid,
  input  logic                    in_hsync,
  input  logic                    in_vsync,
  input  logic [3*DATA_WIDTH-1:0] in_rgb,
  output logic                    pipe_valid,
  output logic                    pipe_hsync,
  output logic                    pipe_vsync,
  output logic [3*DATA_WIDTH-1:0] pipe_rgb,
  output logic [DATA_WIDTH-1:0]   act_threshold,
  output logic [1:0]              act_out_sel,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    frame_err,
  output logic [CNT_W-1:0]        last_lines,
  output logic [15:0]             frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_STOPPING} state_t;

  localparam logic [DATA_WIDTH-1:0] THR_RST = DATA_WIDTH'(50);
  localparam logic [1:0]            SEL_RST = 2'd2;
  localparam logic [CNT_W-1:0]      CNT_MAX = '1;
  localparam logic [CNT_W-1:0]      W_EXP   = CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0]      H_EXP   = CNT_W'(IMG_HEIGHT);

  state_t                    state_q, state_d;
  logic                      single_q, single_d;
  logic                      prev_vsync_q, prev_hsync_q;
  logic                      pipe_valid_q, pipe_hsync_q, pipe_vsync_q;
  logic [3*DATA_WIDTH-1:0]   pipe_rgb_q;
  logic [DATA_WIDTH-1:0]     thr_q;
  logic [1:0]                sel_q;
  logic [CNT_W-1:0]          pix_q, pix_d, line_q, line_d;
  logic                      err_q, err_d;
  logic                      done_q, ferr_q;
  logic [CNT_W-1:0]          last_lines_q;
  logic [15:0]               frame_cnt_q;

  logic vs_rise, vs_fall, hs_fall, pass;

  assign vs_rise = in_vsync & ~prev_vsync_q;
  assign vs_fall = ~in_vsync & prev_vsync_q;
  assign hs_fall = ~in_hsync & prev_hsync_q;

  // A frame is admitted only from its vsync rise; the vs_fall cycle itself is still passed
  assign pass = (state_q == S_RUN) || (state_q == S_STOPPING) ||
                ((state_q == S_ARMED) && vs_rise && !stop);

  // Sequencer next state; stop has priority over start, and a stop landing on the
  // frame's own vs_fall ends the run right there instead of admitting another frame
  always_comb begin
    state_d  = state_q;
    single_d = single_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d  = S_ARMED;
          single_d = single;
        end
      end
      S_ARMED: begin
        if (stop)         state_d = S_IDLE;
        else if (vs_rise) state_d = S_RUN;
      end
      S_RUN: begin
        if (vs_fall)   state_d = (single_q || stop) ? S_IDLE : S_RUN;
        else if (stop) state_d = S_STOPPING;
      end
      S_STOPPING: begin
        if (vs_fall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Geometry counters; a line closing on the vs_fall cycle is folded in before end-of-frame
  always_comb begin
    pix_d  = pix_q;
    line_d = line_q;
    err_d  = err_q;
    if (pass) begin
      if (vs_rise) begin
        pix_d  = '0;
        line_d = '0;
        err_d  = 1'b0;
      end else if (hs_fall) begin
        line_d = (line_q == CNT_MAX) ? line_q : line_q + 1'b1;
        err_d  = err_q | (pix_q != W_EXP);
        pix_d  = '0;
      end else if (in_valid && in_hsync && (pix_q != CNT_MAX)) begin
        pix_d = pix_q + 1'b1;
      end
    end
  end

  // State, edge history, gated pipe stage, shadow config and frame status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      single_q     <= 1'b0;
      prev_vsync_q <= 1'b0;
      prev_hsync_q <= 1'b0;
      pipe_valid_q <= 1'b0;
      pipe_hsync_q <= 1'b0;
      pipe_vsync_q <= 1'b0;
      pipe_rgb_q   <= '0;
      thr_q        <= THR_RST;
      sel_q        <= SEL_RST;
      pix_q        <= '0;
      line_q       <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      ferr_q       <= 1'b0;
      last_lines_q <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      single_q     <= single_d;
      prev_vsync_q <= in_vsync;
      prev_hsync_q <= in_hsync;
      pipe_valid_q <= pass & in_valid;
      pipe_hsync_q <= pass & in_hsync;
      pipe_vsync_q <= pass & in_vsync;
      pipe_rgb_q   <= in_rgb;
      if (pass && vs_rise) begin
        thr_q <= cfg_threshold;
        sel_q <= (cfg_out_sel == 2'd3) ? 2'd2 : cfg_out_sel;
      end
      pix_q  <= pix_d;
      line_q <= line_d;
      err_q  <= err_d;
      done_q <= pass & vs_fall;
      if (pass && vs_fall) begin
        ferr_q       <= err_d | (line_d != H_EXP);
        last_lines_q <= line_d;
        frame_cnt_q  <= frame_cnt_q + 16'd1;
      end else begin
        ferr_q <= 1'b0;
      end
    end
  end

  assign pipe_valid    = pipe_valid_q;
  assign pipe_hsync    = pipe_hsync_q;
  assign pipe_vsync    = pipe_vsync_q;
  assign pipe_rgb      = pipe_rgb_q;
  assign act_threshold = thr_q;
  assign act_out_sel   = sel_q;
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = done_q;
  assign frame_err     = ferr_q;
  assign last_lines    = last_lines_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_image_process_ctrl.sv
// tb/tb_image_process_ctrl.sv - scoreboard bench for image_process_ctrl
module tb_image_process_ctrl;

  localparam int DW = 8;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst_n, start, stop, single;
  logic [DW-1:0] cfg_threshold;
  logic [1:0]    cfg_out_sel;
  logic          in_valid, in_hsync, in_vsync;
  logic [3*DW-1:0] in_rgb;
  logic          pipe_valid, pipe_hsync, pipe_vsync;
  logic [3*DW-1:0] pipe_rgb;
  logic [DW-1:0] act_threshold;
  logic [1:0]    act_out_sel;
  logic          busy, frame_done, frame_err;
  logic [CW-1:0] last_lines;
  logic [15:0]   frame_cnt;

  typedef struct {
    logic          err;
    logic [CW-1:0] lines;
    logic [15:0]   cnt;
  } fr_t;

  logic [3*DW-1:0] exp_pix[$];
  fr_t             exp_fr[$];
  int              total = 0;
  int              bad = 0;
  int              pv_seen = 0;
  logic [15:0]     frames_model = 16'd0;

  image_process_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(8), .IMG_HEIGHT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .single(single),
    .cfg_threshold(cfg_threshold), .cfg_out_sel(cfg_out_sel),
    .in_valid(in_valid), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_rgb(in_rgb),
    .pipe_valid(pipe_valid), .pipe_hsync(pipe_hsync), .pipe_vsync(pipe_vsync), .pipe_rgb(pipe_rgb),
    .act_threshold(act_threshold), .act_out_sel(act_out_sel), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err), .last_lines(last_lines), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock, then sample away from the edge and drain the scoreboard
  task automatic step();
    fr_t f;
    logic [3*DW-1:0] e;
    @(posedge clk);
    #1;
    if (pipe_valid === 1'b1) begin
      pv_seen++;
      if (exp_pix.size() == 0) begin
        chk("unexp_pipe_valid", 32'(pipe_valid), 32'd0);
      end else begin
        e = exp_pix.pop_front();
        chk("pipe_rgb", 32'(pipe_rgb), 32'(e));
        chk("pipe_hsync", 32'(pipe_hsync), 32'd1);
      end
    end
    if (frame_done === 1'b1) begin
      if (exp_fr.size() == 0) begin
        chk("unexp_frame_done", 32'(frame_done), 32'd0);
      end else begin
        f = exp_fr.pop_front();
        chk("frame_err", 32'(frame_err), 32'(f.err));
        chk("last_lines", 32'(last_lines), 32'(f.lines));
        chk("frame_cnt", 32'(frame_cnt), 32'(f.cnt));
      end
    end else if (frame_err !== 1'b0) begin
      chk("frame_err_without_done", 32'(frame_err), 32'd0);
    end
  endtask

  task automatic drive(input logic v, input logic h, input logic vs);
    in_valid = v;
    in_hsync = h;
    in_vsync = vs;
    step();
  endtask

  task automatic send_frame(input bit admit, input int nlines, input int short_line,
                            input int stop_line, input int start_line, input int rst_line,
                            input int thr_line, input logic [DW-1:0] thr_new,
                            input logic [DW-1:0] exp_thr);
    bit adm;
    int pushed;
    int npix;
    fr_t f;
    adm = admit;
    pushed = 0;
    pv_seen = 0;
    drive(0, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 1);
    chk("pipe_vsync_at_rise", 32'(pipe_vsync), 32'(admit));
    if (admit) begin
      chk("act_threshold_at_rise", 32'(act_threshold), 32'(exp_thr));
      chk("act_out_sel_at_rise", 32'(act_out_sel), 32'd1);
    end
    drive(0, 0, 1);
    for (int l = 0; l < nlines; l++) begin
      npix = (l == short_line) ? 7 : 8;
      for (int p = 0; p < npix; p++) begin
        if (p == 0 && l == stop_line)  stop = 1'b1;
        if (p == 0 && l == start_line) start = 1'b1;
        if (p == 0 && l == thr_line)   cfg_threshold = thr_new;
        if (p == 0 && l == rst_line) begin
          rst_n = 1'b0;
          adm = 1'b0;
          frames_model = 16'd0;
        end
        in_rgb = 24'($urandom);
        if (adm) begin
          exp_pix.push_back(in_rgb);
          pushed++;
        end
        drive(1, 1, 1);
        if (p == 0 && l == rst_line) begin
          chk("rst_pipe_valid", 32'(pipe_valid), 32'd0);
          chk("rst_pipe_vsync", 32'(pipe_vsync), 32'd0);
          chk("rst_busy", 32'(busy), 32'd0);
          chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
          chk("rst_act_threshold", 32'(act_threshold), 32'd50);
          chk("rst_act_out_sel", 32'(act_out_sel), 32'd2);
        end
        if (p == 0 && l == thr_line && admit)
          chk("act_threshold_held", 32'(act_threshold), 32'(exp_thr));
        stop = 1'b0;
        start = 1'b0;
        rst_n = 1'b1;
      end
      drive(0, 0, 1);
      drive(0, 0, 1);
    end
    if (adm) begin
      frames_model = frames_model + 16'd1;
      f.err = (short_line >= 0) || (nlines != 4);
      f.lines = CW'(nlines);
      f.cnt = frames_model;
      exp_fr.push_back(f);
    end
    drive(0, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    if (admit) begin
      chk("pipe_valid_count", 32'(pv_seen), 32'(pushed));
      chk("frame_done_seen", 32'(exp_fr.size()), 32'd0);
    end else begin
      chk("blocked_pipe_valid", 32'(pv_seen), 32'd0);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    drive(0, 0, 0);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; single = 1'b0;
    cfg_threshold = 8'd50; cfg_out_sel = 2'd1;
    in_valid = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0; in_rgb = '0;
    step();
    step();
    chk("reset_pipe_valid", 32'(pipe_valid), 32'd0);
    chk("reset_pipe_vsync", 32'(pipe_vsync), 32'd0);
    chk("reset_pipe_rgb", 32'(pipe_rgb), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    chk("reset_last_lines", 32'(last_lines), 32'd0);
    chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("reset_act_threshold", 32'(act_threshold), 32'd50);
    chk("reset_act_out_sel", 32'(act_out_sel), 32'd2);
    rst_n = 1'b1;
    drive(0, 0, 0);

    // continuous capture: full frame, then a threshold change mid-frame
    pulse_start();
    chk("busy_armed", 32'(busy), 32'd1);
    send_frame(1, 4, -1, -1, -1, -1, -1, 8'd0, 8'd50);
    send_frame(1, 4, -1, -1, -1, -1, 1, 8'd80, 8'd50);
    chk("act_threshold_end_frame", 32'(act_threshold), 32'd50);
    // new threshold visible from next frame; stop during line 2 finishes this frame
    send_frame(1, 4, -1, 2, -1, -1, -1, 8'd0, 8'd80);
    chk("busy_after_stop", 32'(busy), 32'd0);
    send_frame(0, 4, -1, -1, -1, -1, -1, 8'd0, 8'd0);

    // start issued mid-frame: that frame blocked, next admitted
    send_frame(0, 4, -1, -1, 1, -1, -1, 8'd0, 8'd0);
    chk("busy_armed_midframe", 32'(busy), 32'd1);
    send_frame(1, 4, 2, -1, -1, -1, -1, 8'd0, 8'd80);
    send_frame(1, 3, -1, -1, -1, -1, -1, 8'd0, 8'd80);

    // reset mid-frame drops the rest of the frame
    send_frame(1, 4, -1, -1, -1, 2, -1, 8'd0, 8'd80);
    chk("busy_after_rst", 32'(busy), 32'd0);

    // start and stop together in IDLE: stop wins
    start = 1'b1;
    stop = 1'b1;
    drive(0, 0, 0);
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop_same_cycle", 32'(busy), 32'd0);

    // single-frame capture
    single = 1'b1;
    pulse_start();
    single = 1'b0;
    send_frame(1, 4, -1, -1, -1, -1, -1, 8'd0, 8'd80);
    chk("busy_after_single", 32'(busy), 32'd0);
    send_frame(0, 4, -1, -1, -1, -1, -1, 8'd0, 8'd0);
    chk("pix_queue_empty", 32'(exp_pix.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
